// File: rtl/spi_target_sync.sv
// SPI target that oversamples sclk, cs_n and sdi in the clk domain; all four CPOL/CPHA modes.
// Received words come out as strobes. Transmit words go through a one-entry valid/ready buffer.
module spi_target_sync #(
    parameter int                    DATA_WIDTH  = 8,
    parameter bit                    CPOL        = 1'b0,
    parameter bit                    CPHA        = 1'b0,
    parameter bit                    MSB_FIRST   = 1'b1,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] FILL        = {DATA_WIDTH{1'b1}},
    localparam int                   BCW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_sdi,
    output logic                  spi_sdo,
    output logic                  spi_sdo_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  tx_underrun,
    output logic [BCW-1:0]        bit_count
);
    // state  | meaning
    // IDLE   | deselected (or waiting for cs_n high after reset)
    // ACTIVE | selected, shifting words
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  sdi_sync_q, sdi_sync_d, vld_q, vld_d;
    logic                    sclk_prev_q, sclk_prev_d, armed_q, armed_d, fresh_q, fresh_d;
    logic [BCW-1:0]          bit_count_q, bit_count_d;
    logic [DATA_WIDTH-1:0]   sh_in_q, sh_in_d, sh_out_q, sh_out_d, buf_q, buf_d, rx_data_q, rx_data_d;
    logic                    buf_full_q, buf_full_d, rx_valid_q, rx_valid_d;
    logic                    frame_start_q, frame_start_d, frame_end_q, frame_end_d;
    logic                    tx_underrun_q, tx_underrun_d, word_load;
    logic                    sclk_s, cs_s, sdi_s, lead_edge, trail_edge, sample_edge, shift_edge;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign lead_edge   = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sdi_sync_d    = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
        vld_d         = {vld_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d   = sclk_s;
        // After reset, only a cs_n high seen through a flushed synchroniser arms frame detection.
        armed_d       = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        sh_in_d       = sh_in_q;
        sh_out_d      = sh_out_q;
        fresh_d       = fresh_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        tx_underrun_d = 1'b0;
        word_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !cs_s) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                    bit_count_d   = '0;
                    fresh_d       = 1'b1;
                    word_load     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                    bit_count_d = '0;
                end else begin
                    if (sample_edge) begin
                        sh_in_d = MSB_FIRST ? {sh_in_q[DATA_WIDTH-2:0], sdi_s}
                                            : {sdi_s, sh_in_q[DATA_WIDTH-1:1]};
                        if (bit_count_q == BCW'(DATA_WIDTH - 1)) begin
                            rx_data_d   = sh_in_d;
                            rx_valid_d  = 1'b1;
                            bit_count_d = '0;
                            fresh_d     = 1'b0;
                        end else begin
                            bit_count_d = bit_count_q + BCW'(1);
                        end
                    end
                    if (shift_edge) begin
                        // CPHA=1: the frame-entry load already drives bit 0 of the first word.
                        if (bit_count_q == '0) begin
                            word_load = !CPHA || !fresh_q;
                        end else begin
                            sh_out_d = MSB_FIRST ? {sh_out_q[DATA_WIDTH-2:0], 1'b0}
                                                 : {1'b0, sh_out_q[DATA_WIDTH-1:1]};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (word_load) begin
            sh_out_d      = buf_full_q ? buf_q : FILL;
            tx_underrun_d = !buf_full_q;
        end
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (word_load && buf_full_q) buf_full_d = 1'b0;
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q   <= {SYNC_STAGES{CPOL}};
            cs_sync_q     <= '1;
            sdi_sync_q    <= '0;
            vld_q         <= '0;
            sclk_prev_q   <= CPOL;
            armed_q       <= 1'b0;
            state_q       <= IDLE;
            bit_count_q   <= '0;
            sh_in_q       <= '0;
            sh_out_q      <= '0;
            fresh_q       <= 1'b0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            sdi_sync_q    <= sdi_sync_d;
            vld_q         <= vld_d;
            sclk_prev_q   <= sclk_prev_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            sh_in_q       <= sh_in_d;
            sh_out_q      <= sh_out_d;
            fresh_q       <= fresh_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign spi_sdo_oe  = (state_q == ACTIVE);
    assign spi_sdo     = spi_sdo_oe && (MSB_FIRST ? sh_out_q[DATA_WIDTH-1] : sh_out_q[0]);
    assign tx_ready    = !buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign tx_underrun = tx_underrun_q;
    assign bit_count   = bit_count_q;
endmodule

// File: tb/tb_spi_target_sync.sv
// Directed bench for spi_target_sync: one instance per mode (0..3), one LSB-first instance,
// and one 16-bit instance, each driven by a bit-banged SPI controller model.
module tb_spi_target_sync;
    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] sclk, cs_n, sdi, tx_valid;
    logic [7:0] txd8 [5];
    logic [15:0] txd16;
    wire  [5:0] sdo_w, sdo_oe_w, tx_ready_w, rx_valid_w, fs_w, fe_w, und_w;
    wire  [7:0] rx8 [5];
    wire  [3:0] bc8 [5];
    wire  [15:0] rx16;
    wire  [4:0] bc16;

    int n_checks = 0;
    int n_errors = 0;
    int rxcnt [6] = '{default: 0};
    int undcnt[6] = '{default: 0};
    int undsnap[6] = '{default: 0};
    int fscnt [6] = '{default: 0};
    int fecnt [6] = '{default: 0};
    logic [15:0] lastrx [6] = '{default: 16'h0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_m8
        spi_target_sync #(
            .DATA_WIDTH(8), .CPOL(g == 2 || g == 3), .CPHA(g == 1 || g == 3), .MSB_FIRST(g != 4)
        ) u_dut (
            .clk(clk), .reset(reset), .spi_sclk(sclk[g]), .spi_cs_n(cs_n[g]), .spi_sdi(sdi[g]),
            .spi_sdo(sdo_w[g]), .spi_sdo_oe(sdo_oe_w[g]), .tx_data(txd8[g]), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready_w[g]), .rx_data(rx8[g]), .rx_valid(rx_valid_w[g]),
            .frame_start(fs_w[g]), .frame_end(fe_w[g]), .tx_underrun(und_w[g]), .bit_count(bc8[g])
        );
    end

    spi_target_sync #(.DATA_WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .spi_sclk(sclk[5]), .spi_cs_n(cs_n[5]), .spi_sdi(sdi[5]),
        .spi_sdo(sdo_w[5]), .spi_sdo_oe(sdo_oe_w[5]), .tx_data(txd16), .tx_valid(tx_valid[5]),
        .tx_ready(tx_ready_w[5]), .rx_data(rx16), .rx_valid(rx_valid_w[5]),
        .frame_start(fs_w[5]), .frame_end(fe_w[5]), .tx_underrun(und_w[5]), .bit_count(bc16)
    );

    function automatic bit f_cpol(input int k); return (k == 2 || k == 3); endfunction
    function automatic bit f_cpha(input int k); return (k == 1 || k == 3); endfunction
    function automatic bit f_msb(input int k);  return (k != 4);           endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe monitor, sampled 2 time units after the active edge.
    always begin
        @(posedge clk);
        #2;
        for (int k = 0; k < 6; k++) begin
            if (und_w[k]) undcnt[k]++;
            if (fs_w[k]) fscnt[k]++;
            if (fe_w[k]) fecnt[k]++;
            if (rx_valid_w[k]) begin
                rxcnt[k]++;
                undsnap[k] = undcnt[k];
            end
        end
        for (int k = 0; k < 5; k++) if (rx_valid_w[k]) lastrx[k] = {8'h00, rx8[k]};
        if (rx_valid_w[5]) lastrx[5] = rx16;
    end

    task automatic push_tx(input int k, input logic [15:0] w);
        int t = 0;
        while (!tx_ready_w[k] && t < 2000) begin
            wait_clk(1);
            t++;
        end
        check("tx_ready_wait", tx_ready_w[k], 1);
        if (k < 5) txd8[k] = w[7:0];
        else txd16 = w;
        tx_valid[k] = 1'b1;
        wait_clk(1);
        tx_valid[k] = 1'b0;
    endtask

    task automatic cs_lo(input int k);
        cs_n[k] = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_hi(input int k);
        wait_clk(HP);
        cs_n[k] = 1'b1;
        wait_clk(8);
    endtask

    task automatic xfer(input int k, input logic [15:0] w, input int width, input int nbits,
                        output logic [15:0] miso);
        int bi;
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            bi = f_msb(k) ? width - 1 - i : i;
            if (!f_cpha(k)) begin
                sdi[k] = w[bi];
                wait_clk(HP);
                miso[bi] = sdo_w[k];
                sclk[k] = ~f_cpol(k);
                wait_clk(HP);
                sclk[k] = f_cpol(k);
            end else begin
                sdi[k] = w[bi];
                sclk[k] = ~f_cpol(k);
                wait_clk(HP);
                miso[bi] = sdo_w[k];
                sclk[k] = f_cpol(k);
                wait_clk(HP);
            end
        end
    endtask

    task automatic two_words(input int k, input int nbuf, input logic [15:0] exp2);
        logic [15:0] m1, m2;
        int b_rx, b_und, b_fs, b_fe;
        b_rx = rxcnt[k]; b_und = undcnt[k]; b_fs = fscnt[k]; b_fe = fecnt[k];
        fork
            begin
                push_tx(k, 16'h00A5);
                if (nbuf > 1) push_tx(k, 16'h003C);
            end
            begin
                cs_lo(k);
                if (!f_cpha(k)) check("first_sdo_bit", sdo_w[k], 1);
                xfer(k, 16'h00DA, 8, 8, m1);
                check("rx_word1", lastrx[k], 16'h00DA);
                xfer(k, 16'h005B, 8, 8, m2);
                check("rx_word2", lastrx[k], 16'h005B);
                cs_hi(k);
            end
        join
        check("tx_word1", m1, 16'h00A5);
        check("tx_word2", m2, exp2);
        check("rx_count", rxcnt[k] - b_rx, 2);
        check("underruns", undsnap[k] - b_und, (nbuf > 1) ? 0 : 1);
        check("frame_start_cnt", fscnt[k] - b_fs, 1);
        check("frame_end_cnt", fecnt[k] - b_fe, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] m;
        int b_rx, b_fe, b_fs, b_und;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) sclk[k] = f_cpol(k);
        cs_n = '1; sdi = '0; tx_valid = '0; txd16 = '0;
        for (int k = 0; k < 5; k++) txd8[k] = '0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(10);
        check("rst_tx_ready", tx_ready_w, 6'h3F);
        check("rst_sdo_oe", sdo_oe_w, 6'h00);
        check("rst_sdo", sdo_w, 6'h00);
        check("rst_bit_count", bc16, 0);
        check("rst_rx_data", rx16, 0);

        // cs_n blip, no sclk edges: empty buffer means the frame-entry load underruns
        b_fs = fscnt[0]; b_fe = fecnt[0]; b_und = undcnt[0]; b_rx = rxcnt[0];
        cs_n[0] = 1'b0;
        wait_clk(4);
        cs_n[0] = 1'b1;
        wait_clk(8);
        check("blip_fs", fscnt[0] - b_fs, 1);
        check("blip_fe", fecnt[0] - b_fe, 1);
        check("blip_und", undcnt[0] - b_und, 1);
        check("blip_rx", rxcnt[0] - b_rx, 0);
        check("blip_oe", sdo_oe_w[0], 0);

        for (int k = 0; k < 5; k++) two_words(k, 2, 16'h003C);
        two_words(0, 1, 16'h00FF);

        // Frame aborted after 5 bits
        b_rx = rxcnt[0]; b_fe = fecnt[0];
        cs_lo(0);
        xfer(0, 16'h0081, 8, 5, m);
        check("abort_bc5", bc8[0], 5);
        cs_hi(0);
        check("abort_rx", rxcnt[0] - b_rx, 0);
        check("abort_fe", fecnt[0] - b_fe, 1);
        check("abort_bc0", bc8[0], 0);
        cs_lo(0);
        xfer(0, 16'h0042, 8, 8, m);
        cs_hi(0);
        check("after_abort_rx", lastrx[0], 16'h0042);
        check("after_abort_cnt", rxcnt[0] - b_rx, 1);

        // 16-bit: full word, then reset mid-word, ignored remainder, fresh frame
        cs_lo(5);
        xfer(5, 16'h1234, 16, 16, m);
        cs_hi(5);
        check("w16_rx", rx16, 16'h1234);
        cs_lo(5);
        xfer(5, 16'hBEEF, 16, 7, m);
        check("w16_bc7", bc16, 7);
        reset = 1'b1;
        #1;
        check("rst_mid_rx", rx16, 0);
        check("rst_mid_bc", bc16, 0);
        check("rst_mid_oe", sdo_oe_w[5], 0);
        check("rst_mid_sdo", sdo_w[5], 0);
        check("rst_mid_ready", tx_ready_w[5], 1);
        check("rst_mid_strobes", {rx_valid_w[5], fs_w[5], fe_w[5], und_w[5]}, 0);
        wait_clk(3);
        reset = 1'b0;
        b_rx = rxcnt[5]; b_fs = fscnt[5];
        xfer(5, 16'hFFFF, 16, 16, m);
        check("ignored_rx", rxcnt[5] - b_rx, 0);
        check("ignored_fs", fscnt[5] - b_fs, 0);
        check("ignored_oe", sdo_oe_w[5], 0);
        cs_hi(5);
        cs_lo(5);
        xfer(5, 16'hBEEF, 16, 16, m);
        cs_hi(5);
        check("w16_beef", lastrx[5], 16'hBEEF);
        check("w16_beef_cnt", rxcnt[5] - b_rx, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
